// File: rtl/i2s_frame_mux_pkg.sv
// Shared constants, header layout and FSM state type for the I2S frame multiplexer.
// The header builder keeps the field packing in one place for RTL and bench alike.
package i2s_frame_mux_pkg;
    localparam int NUM_LANES = 16;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 32;
    localparam int AW        = $clog2(DEPTH);
    localparam int PTR_W     = AW + 1;
    localparam int LANE_W    = $clog2(NUM_LANES);

    localparam logic [7:0] HDR_MAGIC = 8'hA5;
    localparam int HDR_MAGIC_LSB = 24;
    localparam int HDR_LANE_LSB  = 20;
    localparam int HDR_DST_LSB   = 16;
    localparam int HDR_SEQ_LSB   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_e;

    function automatic logic [DATA_W-1:0] make_header(input logic [LANE_W-1:0] lane,
                                                      input logic [3:0]        dst,
                                                      input logic [7:0]        seq);
        logic [DATA_W-1:0] h;
        h = '0;
        h[HDR_MAGIC_LSB +: 8]     = HDR_MAGIC;
        h[HDR_LANE_LSB +: LANE_W] = lane;
        h[HDR_DST_LSB +: 4]       = dst;
        h[HDR_SEQ_LSB +: 8]       = seq;
        return h;
    endfunction
endpackage

// File: rtl/i2s_frame_mux_if.sv
// Stream bundle between i2s_in, the frame multiplexer and the transport.
// The multiplexer takes the slave view; the upstream/downstream side takes master.
interface i2s_frame_mux_if;
    import i2s_frame_mux_pkg::*;

    logic [NUM_LANES-1:0]        s_axis_tvalid;
    logic [NUM_LANES*DATA_W-1:0] s_axis_tdata;
    logic [NUM_LANES-1:0]        s_axis_tlast;

    logic                        m_axis_tvalid;
    logic                        m_axis_tready;
    logic [DATA_W-1:0]           m_axis_tdata;
    logic                        m_axis_tlast;
    logic                        m_axis_tuser;

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/i2s_frame_mux_lane_fifo.sv
// Per-lane rollback FIFO: words become visible to the reader only once their frame's
// tlast is stored; an overflowing frame is rolled back and the rest of it discarded.
module i2s_frame_mux_lane_fifo
    import i2s_frame_mux_pkg::*;
(
    input  logic              mclki,
    input  logic              arst_n,
    input  logic              wr_valid,
    input  logic              wr_last,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              enable,
    input  logic              rd_en,
    output logic              avail,
    output logic [DATA_W:0]   rd_word,
    output logic              ovf_pulse
);
    logic [PTR_W-1:0] wr_q, wr_d, commit_q, commit_d, rd_q, rd_d;
    logic             discard_q, discard_d;
    logic             we;
    logic             full;
    logic [DATA_W:0]  mem_q [DEPTH];

    assign full    = (wr_q[PTR_W-1] != rd_q[PTR_W-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign avail   = (commit_q != rd_q);
    assign rd_word = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d      = wr_q;
        commit_d  = commit_q;
        discard_d = discard_q;
        ovf_pulse = 1'b0;
        we        = 1'b0;
        rd_d      = rd_q + PTR_W'(rd_en);
        if (!enable) begin
            wr_d      = commit_q;
            discard_d = 1'b0;
        end else if (wr_valid) begin
            if (full) begin
                // Roll the partial frame back and skip the remainder up to its tlast.
                wr_d      = commit_q;
                ovf_pulse = 1'b1;
                discard_d = !wr_last;
            end else if (discard_q) begin
                if (wr_last) discard_d = 1'b0;
            end else begin
                we   = 1'b1;
                wr_d = wr_q + PTR_W'(1);
                if (wr_last) commit_d = wr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge mclki or negedge arst_n) begin
        if (!arst_n) begin
            wr_q      <= '0;
            commit_q  <= '0;
            rd_q      <= '0;
            discard_q <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            commit_q  <= commit_d;
            rd_q      <= rd_d;
            discard_q <= discard_d;
        end
    end

    always_ff @(posedge mclki) begin
        if (we) mem_q[wr_q[AW-1:0]] <= {wr_last, wr_data};
    end
endmodule

// File: rtl/i2s_frame_mux.sv
// Round-robin multiplexer of committed per-lane frames onto one output stream,
// each packet led by a header word carrying lane, destination and sequence number.
module i2s_frame_mux
    import i2s_frame_mux_pkg::*;
(
    input  logic                   mclki,
    input  logic                   arst_n,
    i2s_frame_mux_if.slave         bus,
    input  logic [NUM_LANES-1:0]   i_enable,
    input  logic [NUM_LANES*4-1:0] i_dst_fpga_index,
    output logic [NUM_LANES-1:0]   o_overflow
);
    logic [NUM_LANES-1:0] avail, ovf_pulse, rd_en;
    logic [DATA_W:0]      rd_word [NUM_LANES];

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            i2s_frame_mux_lane_fifo u_fifo (
                .mclki     (mclki),
                .arst_n    (arst_n),
                .wr_valid  (bus.s_axis_tvalid[gi]),
                .wr_last   (bus.s_axis_tlast[gi]),
                .wr_data   (bus.s_axis_tdata[gi*DATA_W +: DATA_W]),
                .enable    (i_enable[gi]),
                .rd_en     (rd_en[gi]),
                .avail     (avail[gi]),
                .rd_word   (rd_word[gi]),
                .ovf_pulse (ovf_pulse[gi])
            );
        end
    endgenerate

    state_e              state_q, state_d;
    logic [LANE_W-1:0]   grant_q, grant_d, last_grant_q, last_grant_d;
    logic [LANE_W-1:0]   hit_lane, scan_idx;
    logic                hit, hs, pop, seq_inc;
    logic [7:0]          seq_q [NUM_LANES];
    logic [7:0]          seq_d [NUM_LANES];
    logic                tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
    logic [DATA_W-1:0]   tdata_q, tdata_d;
    logic [NUM_LANES-1:0] ovf_q, ovf_d;
    logic [DATA_W:0]     cur_word;

    assign hs       = tvalid_q & bus.m_axis_tready;
    assign cur_word = rd_word[grant_q];
    assign rd_en    = pop ? (NUM_LANES'(1) << grant_q) : '0;

    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tdata  = tdata_q;
    assign bus.m_axis_tlast  = tlast_q;
    assign bus.m_axis_tuser  = tuser_q;
    assign o_overflow        = ovf_q;

    // Priority starts just after the last granted lane and wraps once round.
    always_comb begin
        hit      = 1'b0;
        hit_lane = last_grant_q;
        scan_idx = last_grant_q;
        for (int i = 1; i <= NUM_LANES; i++) begin
            scan_idx = last_grant_q + LANE_W'(i);
            if (!hit && avail[scan_idx]) begin
                hit      = 1'b1;
                hit_lane = scan_idx;
            end
        end
    end

    always_ff @(posedge mclki or negedge arst_n) begin
        if (!arst_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hit) state_d = HDR;
            HDR:     if (hs) state_d = DATA;
            DATA:    if (hs && tlast_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tvalid_d     = tvalid_q;
        tdata_d      = tdata_q;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        pop          = 1'b0;
        seq_inc      = 1'b0;
        case (state_q)
            IDLE: begin
                tvalid_d = hit;
                tlast_d  = 1'b0;
                tuser_d  = hit;
                tdata_d  = '0;
                if (hit) begin
                    grant_d = hit_lane;
                    tdata_d = make_header(hit_lane, i_dst_fpga_index[{hit_lane, 2'b00} +: 4],
                                          seq_q[hit_lane]);
                end
            end
            HDR, DATA: begin
                if (hs && state_q == DATA && tlast_q) begin
                    last_grant_d = grant_q;
                    tvalid_d     = 1'b0;
                    tdata_d      = '0;
                    tlast_d      = 1'b0;
                    tuser_d      = 1'b0;
                end else if (hs) begin
                    // A committed frame is whole in the FIFO, so the next word is always there.
                    seq_inc  = (state_q == HDR);
                    pop      = 1'b1;
                    tvalid_d = 1'b1;
                    tuser_d  = 1'b0;
                    tlast_d  = cur_word[DATA_W];
                    tdata_d  = cur_word[DATA_W-1:0];
                end
            end
            default: tvalid_d = 1'b0;
        endcase
    end

    always_comb begin
        seq_d = seq_q;
        if (seq_inc) seq_d[grant_q] = seq_q[grant_q] + 8'd1;
        ovf_d = ovf_q | ovf_pulse;
    end

    always_ff @(posedge mclki or negedge arst_n) begin
        if (!arst_n) begin
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            grant_q      <= '0;
            last_grant_q <= LANE_W'(NUM_LANES - 1);
            ovf_q        <= '0;
            for (int i = 0; i < NUM_LANES; i++) seq_q[i] <= 8'd0;
        end else begin
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            ovf_q        <= ovf_d;
            seq_q        <= seq_d;
        end
    end
endmodule
